// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared types and constants for the floo tile-edge stage
package floo_pkg;

    // Per-direction link fencing state
    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } edge_state_e;

    // Physical channel indices within a direction
    localparam int unsigned ChReq  = 0;
    localparam int unsigned ChRsp  = 1;
    localparam int unsigned ChWide = 2;

endpackage

// File: rtl/floo_edge_fifo.sv
// rtl/floo_edge_fifo.sv - single-channel elastic buffer, Depth = 0 is a pass-through
module floo_edge_fifo #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned FlitWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [FlitWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FlitWidth-1:0] out_data_o,
    output logic                 empty_o
);

    if (Depth == 0) begin : g_pass
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign out_data_o  = in_data_i;
        assign empty_o     = 1'b1;

        logic w_unused_clk;
        assign w_unused_clk = clk_i ^ rst_ni;
    end else begin : g_buf
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW = $clog2(Depth + 1);

        logic [FlitWidth-1:0] r_mem [Depth];
        logic [PtrW-1:0]      r_wr_ptr;
        logic [PtrW-1:0]      r_rd_ptr;
        logic [CntW-1:0]      r_count;
        logic                 w_push;
        logic                 w_pop;

        // A full buffer refuses input even while it is popping
        assign in_ready_o  = (r_count < CntW'(Depth));
        assign out_valid_o = (r_count != '0);
        assign out_data_o  = r_mem[r_rd_ptr];
        assign empty_o     = (r_count == '0);
        assign w_push      = in_valid_i && in_ready_o;
        assign w_pop       = out_valid_o && out_ready_i;

        // Payload storage; contents are only meaningful under r_count
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data_i;
            end
        end

        // Pointer and occupancy bookkeeping
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CntW'(1);
                    2'b01:   r_count <= r_count - CntW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/floo_tile_edge.sv
// rtl/floo_tile_edge.sv - buffered, fenceable tile boundary; FLOO_TILE_EDGE_PERF_EN adds flit counters
module floo_tile_edge
    import floo_pkg::*;
#(
    parameter int unsigned NumDirs     = 4,
    parameter int unsigned NumChannels = 3,
    parameter int unsigned FlitWidth   = 128,
    parameter int unsigned Depth       = 2,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [NumDirs-1:0]                                  isolate_i,
    output logic [NumDirs-1:0]                                  isolated_o,
    input  logic [NumDirs-1:0][NumChannels-1:0]                 in_valid_i,
    output logic [NumDirs-1:0][NumChannels-1:0]                 in_ready_o,
    input  logic [NumDirs-1:0][NumChannels-1:0][FlitWidth-1:0]  in_data_i,
    output logic [NumDirs-1:0][NumChannels-1:0]                 out_valid_o,
    input  logic [NumDirs-1:0][NumChannels-1:0]                 out_ready_i,
    output logic [NumDirs-1:0][NumChannels-1:0][FlitWidth-1:0]  out_data_o,
    input  logic                                                cnt_clear_i,
    output logic [NumDirs-1:0][NumChannels-1:0][CntWidth-1:0]   flit_cnt_o
);

    logic [NumDirs-1:0][NumChannels-1:0] w_fifo_in_ready;
    logic [NumDirs-1:0][NumChannels-1:0] w_fifo_out_valid;
    logic [NumDirs-1:0][NumChannels-1:0] w_fifo_empty;
    logic [NumDirs-1:0]                  w_active;
    logic [NumDirs-1:0]                  w_fenced;

    for (genvar d = 0; d < NumDirs; d++) begin : g_dir
        edge_state_e r_state;
        logic        r_isolated;
        logic        w_dir_empty;

        assign w_dir_empty   = &w_fifo_empty[d];
        assign w_active[d]   = (r_state == ACTIVE);
        assign w_fenced[d]   = (r_state == ISOLATED);
        assign isolated_o[d] = r_isolated;

        // Fence sequencing: stop input, let buffered flits leave, then gate the output
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state    <= ACTIVE;
                r_isolated <= 1'b0;
            end else begin
                case (r_state)
                    ACTIVE: begin
                        if (isolate_i[d]) begin
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!isolate_i[d]) begin
                            r_state <= ACTIVE;
                        end else if (w_dir_empty) begin
                            r_state    <= ISOLATED;
                            r_isolated <= 1'b1;
                        end
                    end
                    ISOLATED: begin
                        if (!isolate_i[d]) begin
                            r_state    <= ACTIVE;
                            r_isolated <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= ACTIVE;
                        r_isolated <= 1'b0;
                    end
                endcase
            end
        end

        for (genvar c = 0; c < NumChannels; c++) begin : g_ch
            // Gating valid as well as ready keeps a Depth = 0 link from leaking flits while fenced
            floo_edge_fifo #(
                .Depth     (Depth),
                .FlitWidth (FlitWidth)
            ) u_fifo (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .in_valid_i  (in_valid_i[d][c] & w_active[d]),
                .in_ready_o  (w_fifo_in_ready[d][c]),
                .in_data_i   (in_data_i[d][c]),
                .out_valid_o (w_fifo_out_valid[d][c]),
                .out_ready_i (out_ready_i[d][c] & ~w_fenced[d]),
                .out_data_o  (out_data_o[d][c]),
                .empty_o     (w_fifo_empty[d][c])
            );

            assign in_ready_o[d][c]  = w_fifo_in_ready[d][c] & w_active[d];
            assign out_valid_o[d][c] = w_fifo_out_valid[d][c] & ~w_fenced[d];

`ifdef FLOO_TILE_EDGE_PERF_EN
            logic [CntWidth-1:0] r_cnt;

            // Saturating accepted-flit counter; clear wins over a same-cycle accept
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else if (cnt_clear_i) begin
                    r_cnt <= '0;
                end else if (in_valid_i[d][c] && in_ready_o[d][c] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CntWidth'(1);
                end
            end

            assign flit_cnt_o[d][c] = r_cnt;
`else
            assign flit_cnt_o[d][c] = '0;
`endif
        end
    end

`ifndef FLOO_TILE_EDGE_PERF_EN
    logic w_unused_clear;
    assign w_unused_clear = cnt_clear_i;
`endif

endmodule

// File: tb/tb_floo_tile_edge.sv
// tb/tb_floo_tile_edge.sv - self-checking bench for floo_tile_edge
module tb_floo_tile_edge;
    import floo_pkg::*;

    localparam int ND    = 4;
    localparam int NC    = 3;
    localparam int NV    = ND * NC;
    localparam int FW    = 128;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic                          clk = 1'b0;
    logic                          rst_ni = 1'b1;
    logic [ND-1:0]                 isolate_i;
    logic [ND-1:0]                 isolated_o;
    logic [ND-1:0][NC-1:0]         in_valid_i;
    logic [ND-1:0][NC-1:0]         in_ready_o;
    logic [ND-1:0][NC-1:0][FW-1:0] in_data_i;
    logic [ND-1:0][NC-1:0]         out_valid_o;
    logic [ND-1:0][NC-1:0]         out_ready_i;
    logic [ND-1:0][NC-1:0][FW-1:0] out_data_o;
    logic                          cnt_clear_i;
    logic [ND-1:0][NC-1:0][CW-1:0] flit_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference model: one ordered queue of buffered flits per link, a fencing state per direction
    // (0 = active, 1 = draining, 2 = fenced) and an accepted-flit count per link.
    logic [FW-1:0] mq [NV][$];
    int            ms [ND];
    int            mcnt [NV];

    floo_tile_edge #(
        .NumDirs     (ND),
        .NumChannels (NC),
        .FlitWidth   (FW),
        .Depth       (DEPTH),
        .CntWidth    (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .isolate_i   (isolate_i),
        .isolated_o  (isolated_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .cnt_clear_i (cnt_clear_i),
        .flit_cnt_o  (flit_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [FW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit m_ready(int d, int c);
        return (mq[d*NC+c].size() < DEPTH) && (ms[d] == 0);
    endfunction

    function automatic bit m_valid(int d, int c);
        return (mq[d*NC+c].size() > 0) && (ms[d] != 2);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NV; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
        for (int d = 0; d < ND; d++) ms[d] = 0;
    endtask

    // Apply the handshakes implied by the current inputs to the model, then cross one clock edge.
    task automatic advance();
        bit empty [ND];
        bit push;
        bit pop;
        int k;
        for (int d = 0; d < ND; d++) begin
            empty[d] = 1'b1;
            for (int c = 0; c < NC; c++) if (mq[d*NC+c].size() != 0) empty[d] = 1'b0;
        end
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NC; c++) begin
                k    = d * NC + c;
                push = in_valid_i[d][c] && m_ready(d, c);
                pop  = m_valid(d, c) && out_ready_i[d][c];
                if (pop) mq[k].delete(0);
                if (push) mq[k].push_back(in_data_i[d][c]);
`ifdef FLOO_TILE_EDGE_PERF_EN
                if (cnt_clear_i) mcnt[k] = 0;
                else if (push && mcnt[k] < CMAX) mcnt[k] = mcnt[k] + 1;
`endif
            end
            if (ms[d] == 0) begin
                if (isolate_i[d]) ms[d] = 1;
            end else if (ms[d] == 1) begin
                if (!isolate_i[d]) ms[d] = 0;
                else if (empty[d]) ms[d] = 2;
            end else begin
                if (!isolate_i[d]) ms[d] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        in_valid_i  = '0;
        out_ready_i = '1;
        isolate_i   = '0;
        cnt_clear_i = 1'b0;
        repeat (4) advance();
    endtask

    task automatic test_reset();
        #2;
        rst_ni = 1'b0;
        m_reset();
        #2;
        checks++; if (out_valid_o !== '0) begin errors++; $display("FAIL reset_out_valid: got %h want 0", out_valid_o); end
        checks++; if (isolated_o !== '0) begin errors++; $display("FAIL reset_isolated: got %h want 0", isolated_o); end
        checks++; if (in_ready_o !== '1) begin errors++; $display("FAIL reset_in_ready: got %h want all ones", in_ready_o); end
        checks++; if (flit_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", flit_cnt_o); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid_o !== '0) begin errors++; $display("FAIL post_reset_out_valid: got %h want 0", out_valid_o); end
        checks++; if (in_ready_o !== '1) begin errors++; $display("FAIL post_reset_in_ready: got %h want all ones", in_ready_o); end
    endtask

    task automatic test_streaming();
        out_ready_i = '1;
        for (int n = 1; n <= 16; n++) begin
            in_valid_i[0][ChReq] = 1'b1;
            in_data_i[0][ChReq]  = FW'(n);
            checks++;
            if (in_ready_o[0][ChReq] !== 1'b1) begin
                errors++; $display("FAIL stream_ready n=%0d: got %b want 1", n, in_ready_o[0][ChReq]);
            end
            advance();
            checks++;
            if (out_valid_o[0][ChReq] !== 1'b1 || out_data_o[0][ChReq] !== FW'(n)) begin
                errors++; $display("FAIL stream_out n=%0d: got v=%b d=%h want v=1 d=%h",
                                   n, out_valid_o[0][ChReq], out_data_o[0][ChReq], FW'(n));
            end
        end
        in_valid_i[0][ChReq] = 1'b0;
        advance();
        checks++;
        if (out_valid_o[0][ChReq] !== 1'b0) begin
            errors++; $display("FAIL stream_tail: got v=%b want 0", out_valid_o[0][ChReq]);
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] a, b, c;
        settle();
        a = rnd(); b = rnd(); c = rnd();
        out_ready_i[0][ChReq] = 1'b0;
        in_valid_i[0][ChReq]  = 1'b1;
        in_data_i[0][ChReq]   = a;
        advance();
        checks++;
        if (in_ready_o[0][ChReq] !== 1'b1 || out_data_o[0][ChReq] !== a) begin
            errors++; $display("FAIL bp_first: got r=%b d=%h want r=1 d=%h", in_ready_o[0][ChReq], out_data_o[0][ChReq], a);
        end
        in_data_i[0][ChReq] = b;
        advance();
        checks++;
        if (in_ready_o[0][ChReq] !== 1'b0) begin
            errors++; $display("FAIL bp_full: got r=%b want 0", in_ready_o[0][ChReq]);
        end
        in_data_i[0][ChReq] = c;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (in_ready_o[0][ChReq] !== 1'b0 || out_valid_o[0][ChReq] !== 1'b1 || out_data_o[0][ChReq] !== a) begin
                errors++; $display("FAIL bp_stall i=%0d: got r=%b v=%b d=%h want r=0 v=1 d=%h",
                                   i, in_ready_o[0][ChReq], out_valid_o[0][ChReq], out_data_o[0][ChReq], a);
            end
        end
        out_ready_i[0][ChReq] = 1'b1;
        advance();
        checks++;
        if (out_data_o[0][ChReq] !== b || in_ready_o[0][ChReq] !== 1'b1) begin
            errors++; $display("FAIL bp_release: got r=%b d=%h want r=1 d=%h", in_ready_o[0][ChReq], out_data_o[0][ChReq], b);
        end
        advance();
        checks++;
        if (out_data_o[0][ChReq] !== c) begin
            errors++; $display("FAIL bp_resume: got d=%h want %h", out_data_o[0][ChReq], c);
        end
        in_valid_i[0][ChReq] = 1'b0;
        advance();
        checks++;
        if (out_valid_o[0][ChReq] !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got v=%b want 0", out_valid_o[0][ChReq]);
        end
    endtask

    task automatic test_drain_and_resume();
        logic [FW-1:0] x, y, z;
        settle();
        x = rnd(); y = rnd(); z = rnd();
        out_ready_i[1][ChWide] = 1'b0;
        in_valid_i[1][ChWide]  = 1'b1;
        in_data_i[1][ChWide]   = x;
        advance();
        in_data_i[1][ChWide]   = y;
        advance();
        in_valid_i[1][ChWide]  = 1'b0;
        isolate_i[1] = 1'b1;
        advance();
        checks++;
        if (in_ready_o[1] !== '0 || isolated_o[1] !== 1'b0 || in_ready_o[0] !== '1) begin
            errors++; $display("FAIL drain_enter: got r1=%b iso1=%b r0=%b want r1=000 iso1=0 r0=111",
                               in_ready_o[1], isolated_o[1], in_ready_o[0]);
        end
        advance();
        checks++;
        if (isolated_o[1] !== 1'b0 || out_valid_o[1][ChWide] !== 1'b1 || out_data_o[1][ChWide] !== x) begin
            errors++; $display("FAIL drain_hold: got iso=%b v=%b d=%h want iso=0 v=1 d=%h",
                               isolated_o[1], out_valid_o[1][ChWide], out_data_o[1][ChWide], x);
        end
        out_ready_i[1][ChWide] = 1'b1;
        advance();
        checks++;
        if (isolated_o[1] !== 1'b0 || out_data_o[1][ChWide] !== y) begin
            errors++; $display("FAIL drain_pop1: got iso=%b d=%h want iso=0 d=%h", isolated_o[1], out_data_o[1][ChWide], y);
        end
        advance();
        checks++;
        if (isolated_o[1] !== 1'b0 || out_valid_o[1][ChWide] !== 1'b0) begin
            errors++; $display("FAIL drain_pop2: got iso=%b v=%b want iso=0 v=0", isolated_o[1], out_valid_o[1][ChWide]);
        end
        advance();
        checks++;
        if (isolated_o !== 4'b0010 || in_ready_o[1] !== '0 || in_ready_o[0] !== '1) begin
            errors++; $display("FAIL drain_isolated: got iso=%b r1=%b r0=%b want iso=0010 r1=000 r0=111",
                               isolated_o, in_ready_o[1], in_ready_o[0]);
        end
        in_valid_i[1][ChReq] = 1'b1;
        in_data_i[1][ChReq]  = z;
        advance();
        checks++;
        if (in_ready_o[1] !== '0 || out_valid_o[1] !== '0) begin
            errors++; $display("FAIL iso_fenced: got r=%b v=%b want r=000 v=000", in_ready_o[1], out_valid_o[1]);
        end
        isolate_i[1] = 1'b0;
        advance();
        checks++;
        if (isolated_o[1] !== 1'b0 || in_ready_o[1] !== '1 || out_valid_o[1][ChReq] !== 1'b0) begin
            errors++; $display("FAIL iso_exit: got iso=%b r=%b v=%b want iso=0 r=111 v=0",
                               isolated_o[1], in_ready_o[1], out_valid_o[1][ChReq]);
        end
        advance();
        checks++;
        if (out_valid_o[1][ChReq] !== 1'b1 || out_data_o[1][ChReq] !== z) begin
            errors++; $display("FAIL iso_resume: got v=%b d=%h want v=1 d=%h", out_valid_o[1][ChReq], out_data_o[1][ChReq], z);
        end
        in_valid_i[1][ChReq] = 1'b0;
        advance();
        checks++;
        if (out_valid_o[1][ChReq] !== 1'b0) begin
            errors++; $display("FAIL iso_no_dup: got v=%b want 0", out_valid_o[1][ChReq]);
        end
    endtask

    task automatic test_abort();
        logic [FW-1:0] w;
        settle();
        w = rnd();
        out_ready_i[2][ChRsp] = 1'b0;
        in_valid_i[2][ChRsp]  = 1'b1;
        in_data_i[2][ChRsp]   = w;
        advance();
        in_valid_i[2][ChRsp]  = 1'b0;
        isolate_i[2] = 1'b1;
        advance();
        checks++;
        if (in_ready_o[2][ChRsp] !== 1'b0 || isolated_o[2] !== 1'b0) begin
            errors++; $display("FAIL abort_drain: got r=%b iso=%b want r=0 iso=0", in_ready_o[2][ChRsp], isolated_o[2]);
        end
        isolate_i[2] = 1'b0;
        advance();
        checks++;
        if (in_ready_o[2][ChRsp] !== 1'b1 || out_valid_o[2][ChRsp] !== 1'b1 || out_data_o[2][ChRsp] !== w) begin
            errors++; $display("FAIL abort_recover: got r=%b v=%b d=%h want r=1 v=1 d=%h",
                               in_ready_o[2][ChRsp], out_valid_o[2][ChRsp], out_data_o[2][ChRsp], w);
        end
        out_ready_i[2][ChRsp] = 1'b1;
        advance();
        checks++;
        if (out_valid_o[2][ChRsp] !== 1'b0) begin
            errors++; $display("FAIL abort_flush: got v=%b want 0", out_valid_o[2][ChRsp]);
        end
    endtask

    task automatic test_reset_mid();
        settle();
        out_ready_i[3][ChReq] = 1'b0;
        in_valid_i[3][ChReq]  = 1'b1;
        in_data_i[3][ChReq]   = rnd();
        advance();
        in_valid_i[3][ChReq]  = 1'b0;
        checks++;
        if (out_valid_o[3][ChReq] !== 1'b1) begin
            errors++; $display("FAIL rst_mid_setup: got v=%b want 1", out_valid_o[3][ChReq]);
        end
        rst_ni = 1'b0;
        m_reset();
        #1;
        checks++;
        if (out_valid_o !== '0) begin
            errors++; $display("FAIL rst_mid_immediate: got v=%h want 0", out_valid_o);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_o !== '0 || in_ready_o !== '1) begin
            errors++; $display("FAIL rst_mid_release: got v=%h r=%h want v=0 r=all ones", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0][NC-1:0]         er;
        logic [ND-1:0][NC-1:0]         ev;
        logic [ND-1:0][NC-1:0][CW-1:0] ec;
        logic [ND-1:0]                 ei;
        int k;
        settle();
        for (int n = 0; n < 400; n++) begin
            in_valid_i  = NV'($urandom);
            out_ready_i = NV'($urandom | $urandom);
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < NC; c++) in_data_i[d][c] = rnd();
            if ($urandom_range(0, 15) == 0) isolate_i[$urandom_range(0, ND-1)] ^= 1'b1;
            cnt_clear_i = ($urandom_range(0, 39) == 0);
            advance();
            for (int d = 0; d < ND; d++) begin
                ei[d] = (ms[d] == 2);
                for (int c = 0; c < NC; c++) begin
                    k        = d * NC + c;
                    er[d][c] = m_ready(d, c);
                    ev[d][c] = m_valid(d, c);
                    ec[d][c] = mcnt[k][CW-1:0];
                    if (ev[d][c]) begin
                        checks++;
                        if (out_data_o[d][c] !== mq[k][0]) begin
                            errors++; $display("FAIL rnd_data n=%0d d=%0d c=%0d: got %h want %h", n, d, c, out_data_o[d][c], mq[k][0]);
                        end
                    end
                end
            end
            checks++; if (in_ready_o !== er) begin errors++; $display("FAIL rnd_ready n=%0d: got %h want %h", n, in_ready_o, er); end
            checks++; if (out_valid_o !== ev) begin errors++; $display("FAIL rnd_valid n=%0d: got %h want %h", n, out_valid_o, ev); end
            checks++; if (isolated_o !== ei) begin errors++; $display("FAIL rnd_isolated n=%0d: got %b want %b", n, isolated_o, ei); end
            checks++; if (flit_cnt_o !== ec) begin errors++; $display("FAIL rnd_cnt n=%0d: got %h want %h", n, flit_cnt_o, ec); end
        end
        cnt_clear_i = 1'b0;
        settle();
    endtask

    task automatic test_counters();
        settle();
`ifdef FLOO_TILE_EDGE_PERF_EN
        cnt_clear_i = 1'b1;
        advance();
        cnt_clear_i = 1'b0;
        checks++;
        if (flit_cnt_o !== '0) begin errors++; $display("FAIL cnt_clear_all: got %h want 0", flit_cnt_o); end
        in_valid_i[0][ChRsp] = 1'b1;
        repeat (20) begin
            in_data_i[0][ChRsp] = rnd();
            advance();
        end
        in_valid_i[0][ChRsp] = 1'b0;
        advance();
        checks++;
        if (flit_cnt_o[0][ChRsp] !== CW'(CMAX)) begin
            errors++; $display("FAIL cnt_saturate: got %0d want %0d", flit_cnt_o[0][ChRsp], CMAX);
        end
        in_valid_i[0][ChRsp] = 1'b1;
        cnt_clear_i = 1'b1;
        advance();
        checks++;
        if (flit_cnt_o[0][ChRsp] !== '0) begin
            errors++; $display("FAIL cnt_clear_priority: got %0d want 0", flit_cnt_o[0][ChRsp]);
        end
        cnt_clear_i = 1'b0;
        advance();
        checks++;
        if (flit_cnt_o[0][ChRsp] !== CW'(1)) begin
            errors++; $display("FAIL cnt_after_clear: got %0d want 1", flit_cnt_o[0][ChRsp]);
        end
        in_valid_i[0][ChRsp] = 1'b0;
`else
        in_valid_i[0][ChRsp] = 1'b1;
        cnt_clear_i = 1'b0;
        repeat (20) begin
            in_data_i[0][ChRsp] = rnd();
            advance();
        end
        in_valid_i[0][ChRsp] = 1'b0;
        advance();
        checks++;
        if (flit_cnt_o !== '0) begin errors++; $display("FAIL cnt_disabled: got %h want 0", flit_cnt_o); end
`endif
    endtask

    initial begin
        isolate_i   = '0;
        in_valid_i  = '0;
        in_data_i   = '0;
        out_ready_i = '0;
        cnt_clear_i = 1'b0;
        m_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain_and_resume();
        test_abort();
        test_reset_mid();
        test_random();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
